// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port synchronous pixel memory between
// the VGA scanout reader (always wins) and a buffered pixel writer. Writes
// are queued in a small FIFO and drained on cycles without a scanout read.
// Optional statistics outputs (stall_cnt, max_fill) are present only when
// the macro VGA_ARB_STATS_EN is defined.
module vga_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_req,
  input  logic [ADDR_W-1:0]             scan_addr,
  output logic                          scan_valid,
  output logic [DATA_W-1:0]             scan_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          fifo_empty,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   max_fill
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // The state records which requester owns the memory in a given cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] scan_hold_q, scan_hold_d;
  logic              push, pop;

  // Ready comes only from the registered count, so a pop in a full cycle
  // does not reopen the FIFO until the following cycle.
  assign wr_ready   = !rst && (count_q != FULL_CNT);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_d == DRAIN);
  assign fifo_empty = empty_q;

  // Grant register: remembers this cycle's grant so read data can be tagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision: scanout first, then drain pending writes, else idle.
  always_comb begin
    state_d = IDLE;
    if (rst) begin
      state_d = IDLE;
    end else if (scan_req) begin
      state_d = SCAN;
    end else if (!empty_q) begin
      state_d = DRAIN;
    end
  end

  // Memory port driven straight from the grant issued in this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_d)
      SCAN: begin
        mem_en   = 1'b1;
        mem_addr = scan_addr;
      end
      DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr_q[rd_ptr_q];
        mem_wdata = fifo_data_q[rd_ptr_q];
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping for this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    empty_d = (count_d == '0);
  end

  // FIFO control registers; reset throws away anything still queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Read data is live the cycle after a scan grant and held otherwise.
  assign scan_valid  = (state_q == SCAN);
  assign scan_data   = scan_valid ? mem_rdata : scan_hold_q;
  assign scan_hold_d = scan_data;

  // Hold register that keeps the last returned pixel stable between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_hold_q <= '0;
    end else begin
      scan_hold_q <= scan_hold_d;
    end
  end

`ifdef VGA_ARB_STATS_EN
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] max_fill_q, max_fill_d;

  assign stall_cnt = stall_cnt_q;
  assign max_fill  = max_fill_q;

  // Saturating stall counter and FIFO high-water mark.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    max_fill_d  = max_fill_q;
    if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (count_q > max_fill_q) begin
      max_fill_d = count_q;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      max_fill_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      max_fill_q  <= max_fill_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: drives directed and random traffic into the arbiter,
// emulates the framebuffer BRAM, and compares every cycle against a
// queue-based model of the arbitration rules. Stats ports follow
// VGA_ARB_STATS_EN.
module tb_vga_mem_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          scanReq = 1'b0;
  logic [AW-1:0] scanAddr = '0;
  logic          wrValid = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic          scanValid;
  logic [DW-1:0] scanData;
  logic          wrReady;
  logic          fifoEmpty;
  logic          memEn;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata = '0;
`ifdef VGA_ARB_STATS_EN
  logic [15:0]   stallCnt;
  logic [4:0]    maxFill;
  int            expStall = 0;
  int            expMax = 0;
`endif

  logic [DW-1:0] fbMem  [0:(1<<AW)-1];
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  wr_t           pq[$];
  bit            expValid = 1'b0;
  logic [DW-1:0] expData = '0;
  bit            resetSeen = 1'b0;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] burstData [0:16];

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clock),
    .rst        (reset),
    .scan_req   (scanReq),
    .scan_addr  (scanAddr),
    .scan_valid (scanValid),
    .scan_data  (scanData),
    .wr_valid   (wrValid),
    .wr_ready   (wrReady),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .fifo_empty (fifoEmpty),
    .mem_en     (memEn),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata)
`ifdef VGA_ARB_STATS_EN
    ,
    .stall_cnt  (stallCnt),
    .max_fill   (maxFill)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input logic [AW-1:0] sa,
                               input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(posedge clock);
    #1;
    reset    = r;
    scanReq  = s;
    scanAddr = sa;
    wrValid  = wv;
    wrAddr   = wa;
    wrData   = wd;
  endtask

  // Framebuffer BRAM: one access per cycle, registered read data.
  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      fbMem[i]  = '0;
      refMem[i] = '0;
    end
    forever begin
      @(posedge clock);
      if (memEn && memWe) fbMem[memAddr] = memWdata;
      if (memEn && !memWe) memRdata <= fbMem[memAddr];
    end
  end

  // Reference model: pending-write queue plus a shadow of memory contents.
  task automatic modelStep();
    int  sz;
    bit  rdy;
    wr_t e;
    if (reset) begin
      pq.delete();
      expValid  = 1'b0;
      expData   = '0;
      resetSeen = 1'b1;
`ifdef VGA_ARB_STATS_EN
      expStall = 0;
      expMax   = 0;
`endif
    end else begin
      sz  = pq.size();
      rdy = (sz < DEPTH);
`ifdef VGA_ARB_STATS_EN
      if (wrValid && !rdy && expStall < 65535) expStall++;
      if (sz > expMax) expMax = sz;
`endif
      if (scanReq) begin
        expValid = 1'b1;
        expData  = refMem[scanAddr];
      end else begin
        expValid = 1'b0;
        if (sz > 0) begin
          e = pq.pop_front();
          refMem[e.a] = e.d;
        end
      end
      if (wrValid && rdy) begin
        e.a = wrAddr;
        e.d = wrData;
        pq.push_back(e);
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    modelStep();
  end

  // Per-cycle comparison of every DUT output against the model.
  task automatic compareCycle();
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    g  = reset ? 0 : (scanReq ? 1 : ((pq.size() > 0) ? 2 : 0));
    ea = '0;
    ed = '0;
    if (g == 1) ea = scanAddr;
    if (g == 2) begin
      ea = pq[0].a;
      ed = pq[0].d;
    end
    checkOutput("scan_valid", 32'(scanValid), 32'(expValid));
    checkOutput("scan_data", 32'(scanData), 32'(expData));
    checkOutput("wr_ready", 32'(wrReady), 32'(!reset && (pq.size() < DEPTH)));
    checkOutput("fifo_empty", 32'(fifoEmpty), 32'(pq.size() == 0));
    checkOutput("mem_en", 32'(memEn), 32'(g != 0));
    checkOutput("mem_we", 32'(memWe), 32'(g == 2));
    checkOutput("mem_addr", 32'(memAddr), 32'(ea));
    if (g != 1) checkOutput("mem_wdata", 32'(memWdata), 32'(ed));
`ifdef VGA_ARB_STATS_EN
    checkOutput("stall_cnt", 32'(stallCnt), 32'(expStall));
    checkOutput("max_fill", 32'(maxFill), 32'(expMax));
`endif
  endtask

  initial forever begin
    @(negedge clock);
    if (resetSeen) compareCycle();
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    int k;
    for (int i = 0; i <= 16; i++) burstData[i] = DW'($urandom);

    applyStimulus(1, 0, '0, 0, '0, '0);
    applyStimulus(1, 0, '0, 0, '0, '0);

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, 0, '0, '0);
      @(negedge clock);
      checkOutput("idle_empty", 32'(fifoEmpty), 32'd1);
      checkOutput("idle_ready", 32'(wrReady), 32'd1);
      checkOutput("idle_en", 32'(memEn), 32'd0);
      checkOutput("idle_valid", 32'(scanValid), 32'd0);
    end

    // Three writes drained on consecutive cycles in order.
    applyStimulus(0, 0, '0, 1, 15'd5, 12'hF00);
    @(negedge clock);
    checkOutput("w3_we0", 32'(memWe), 32'd0);
    applyStimulus(0, 0, '0, 1, 15'd6, 12'h0F0);
    @(negedge clock);
    checkOutput("w3_we1", 32'(memWe), 32'd1);
    checkOutput("w3_addr1", 32'(memAddr), 32'd5);
    applyStimulus(0, 0, '0, 1, 15'd7, 12'h00F);
    @(negedge clock);
    checkOutput("w3_addr2", 32'(memAddr), 32'd6);
    checkOutput("w3_data2", 32'(memWdata), 32'h0F0);
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("w3_addr3", 32'(memAddr), 32'd7);
    checkOutput("w3_data3", 32'(memWdata), 32'h00F);
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("w3_empty", 32'(fifoEmpty), 32'd1);
    checkOutput("w3_we_end", 32'(memWe), 32'd0);
    checkOutput("w3_bram5", 32'(fbMem[5]), 32'hF00);

    // Scanout held high: writes pile up until the FIFO is full.
    k = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1, AW'(c), 1, AW'(200 + k), burstData[k]);
      @(negedge clock);
      checkOutput("burst_we", 32'(memWe), 32'd0);
      if (pq.size() < DEPTH) k++;
    end
    checkOutput("burst_full_ready", 32'(wrReady), 32'd0);

    // Drop scanout: sixteen drain cycles, ready returns after the first pop.
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("drain_ready0", 32'(wrReady), 32'd0);
    checkOutput("drain_first_addr", 32'(memAddr), 32'd200);
`ifdef VGA_ARB_STATS_EN
    checkOutput("stall_burst", 32'(stallCnt), 32'd24);
`endif
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("drain_ready1", 32'(wrReady), 32'd1);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 0, '0, 0, '0, '0);
      @(negedge clock);
      checkOutput("drain_we", 32'(memWe), 32'd1);
    end
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("drain_done_empty", 32'(fifoEmpty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, AW'(200 + i), 0, '0, '0);
      applyStimulus(0, 0, '0, 0, '0, '0);
      @(negedge clock);
      checkOutput("readback_valid", 32'(scanValid), 32'd1);
      checkOutput("readback_data", 32'(scanData), 32'(burstData[i]));
    end

    // Write then read back the same pixel.
    applyStimulus(0, 0, '0, 1, 15'd100, 12'hABC);
    applyStimulus(0, 0, '0, 0, '0, '0);
    applyStimulus(0, 0, '0, 0, '0, '0);
    applyStimulus(0, 1, 15'd100, 0, '0, '0);
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("abc_valid", 32'(scanValid), 32'd1);
    checkOutput("abc_data", 32'(scanData), 32'hABC);

    // Reset with writes pending and a read requested.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 15'd5, 1, AW'(300 + i), DW'(i + 1));
    applyStimulus(1, 1, 15'd6, 0, '0, '0);
    applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("rst_valid", 32'(scanValid), 32'd0);
    checkOutput("rst_empty", 32'(fifoEmpty), 32'd1);
`ifdef VGA_ARB_STATS_EN
    checkOutput("rst_stall", 32'(stallCnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, '0, 0, '0, '0);
      @(negedge clock);
      checkOutput("rst_no_we", 32'(memWe), 32'd0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                    AW'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0),
                    AW'($urandom_range(0, 31)), DW'($urandom));
    end
    applyStimulus(0, 0, '0, 0, '0, '0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, 0, '0, '0);
    @(negedge clock);
    checkOutput("final_empty", 32'(fifoEmpty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
